text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Writer side of the text-mode display path: consumes an ASCII byte stream and writes character codes into the dual-port character buffer that the text renderer reads.
- Tracks the cursor.
- Interprets CR, LF and BS.
- Wraps at end of line.
- Scrolls by rotating a physical-row base (hardware scroll) and blanking the newly exposed line.
- Sits between the UART/CPU character source and the write port of the character RAM.

Parameters:
COLS, 80, characters per line (640/8)
ROWS, 30, lines per screen (480/16)
ADDR_W, 12, character buffer address width; requires ROWS*COLS <= 2^ADDR_W
BLANK, 8'h20, code written when clearing cells

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
char_valid  input  1  char_data is valid
char_data  input  8  ASCII byte
char_ready  output  1  block accepts a byte this cycle
clear_req  input  1  single-cycle request to blank the whole screen and home the cursor
wr_en  output  1  character RAM write strobe
wr_addr  output  ADDR_W  RAM address = phys_row*COLS + col
wr_data  output  8  byte to write
cursor_col  output  7  logical cursor column, 0..COLS-1
cursor_row  output  5  logical cursor row, 0..ROWS-1
scroll_base  output  5  physical buffer row shown at screen top; the renderer adds it mod ROWS
busy  output  1  multi-cycle clear in progress

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE. char_ready rises on the first clk edge after rst deasserts.
- Outputs wr_en, wr_addr and wr_data are registered. A write appears 1 cycle after the accepting edge. wr_en is a one-cycle pulse per cell.
- Handshake: a byte is transferred on a rising edge with char_valid && char_ready. char_ready = 1 only in IDLE with no clear pending.
- States:
  - IDLE: waits for a byte or a clear.
  - CLR_LINE: blanks one line.
  - CLR_ALL: blanks the full screen.
- phys_row = (scroll_base + cursor_row) mod ROWS. Computed without overflow: the sum is at most 2*ROWS-2; subtract ROWS when the sum >= ROWS.
- Byte handling in IDLE:
  - Printable 0x20-0x7E: write at (phys_row, cursor_col), then advance col. At col == COLS-1, set col = 0 and perform a newline.
  - 0x0D CR: col = 0; no write.
  - 0x0A LF: col = 0 and perform a newline; no write.
  - 0x08 BS: if col > 0, decrement col and write BLANK at the new col. If col == 0, no-op (no wrap to the previous line).
  - Any other code: accepted and discarded; no write, cursor unchanged.
- Newline:
  - If cursor_row < ROWS-1: row+1; stays in IDLE.
  - If cursor_row == ROWS-1: row stays; scroll_base = (scroll_base+1) mod ROWS (wraps 29 -> 0). Enter CLR_LINE targeting the old scroll_base row, which becomes the new bottom line.
- CLR_LINE:
  - Writes BLANK to cols 0..COLS-1 of that physical row, one per cycle: COLS consecutive wr_en pulses.
  - busy = 1 and char_ready = 0 throughout; returns to IDLE.
  - A printable char that triggers wrap+scroll writes its own cell first, then the clear follows.
- clear_req:
  - Sampled only in IDLE. Beats char_valid in the same cycle; that byte is not accepted.
  - If it arrives while busy, it is latched and serviced on return to IDLE.
  - Entering CLR_ALL immediately sets cursor = (0,0) and scroll_base = 0.
  - Writes BLANK to addresses 0..ROWS*COLS-1 in order: ROWS*COLS pulses, busy = 1, then IDLE.
- rst during any clear aborts it immediately. Partially cleared RAM is not repaired.
- Throughput: 1 byte per cycle sustained while no scroll occurs.

Test Plan:
- Reset release, then send 'H','i' back-to-back -> wr_en at addr 0 data 0x48, then addr 1 data 0x69; cursor_col = 2; char_ready held 1.
- Cursor at (0,5), send 0x0D then 0x0A -> no writes; cursor = (1,0); scroll_base = 0.
- Cursor at col 79 row 3, send 'A' -> write addr 3*80+79 = 319 data 0x41; cursor = (4,0); busy stays 0.
- Cursor row 29 with scroll_base 0, send 0x0A -> scroll_base = 1; char_ready = 0 for 80 cycles; 80 writes of 0x20 at addrs 0..79; cursor = (29,0).
- Cursor (2,0) send 0x08 -> no write, cursor unchanged. Cursor (2,4) send 0x08 -> write 0x20 at addr 163; col = 3.
- clear_req and char_valid asserted together -> byte not accepted; 2400 writes of 0x20 at addrs 0..2399; cursor = (0,0); scroll_base = 0. Assert rst at write 1000 -> wr_en = 0 and all outputs 0 immediately.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer
// Writer side of the text-mode display path. Consumes an ASCII byte stream
// and writes character codes into the write port of the character RAM. It
// tracks the cursor, interprets CR/LF/BS, wraps at end of line, and scrolls
// by rotating a physical-row base. On a scroll the newly exposed line is
// blanked.
//
// Ports
//   clk, rst                    system clock, async active-high reset
//   char_valid/char_data        incoming byte, transferred when char_ready
//   char_ready                  block accepts a byte this cycle
//   clear_req                   one-cycle request to blank screen and home
//   wr_en/wr_addr/wr_data       registered RAM write port, one pulse per cell
//   cursor_col/cursor_row       logical cursor position
//   scroll_base                 physical row shown at the top of the screen
//   busy                        a multi-cycle clear is in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accept bytes, or start a clear (requested or latched)
// CLR_LINE | blank one physical row after a scroll, one cell per cycle
// CLR_ALL  | blank the whole buffer, addresses 0..ROWS*COLS-1

module text_console_writer #(
   parameter int          COLS   = 80,
   parameter int          ROWS   = 30,
   parameter int          ADDR_W = 12,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              char_valid,
   input  logic [7:0]        char_data,
   output logic              char_ready,
   input  logic              clear_req,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cursor_col,
   output logic [4:0]        cursor_row,
   output logic [4:0]        scroll_base,
   output logic              busy
);

   localparam int          CELLS      = ROWS * COLS;
   localparam logic [ADDR_W:0]   CELLS_CNT  = (ADDR_W + 1)'(CELLS);
   localparam logic [ADDR_W:0]   COLS_CNT   = (ADDR_W + 1)'(COLS);
   localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);
   localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_LINE = 2'd1,
      CLR_ALL  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          col_q, col_d;
   logic [4:0]          row_q, row_d;
   logic [4:0]          base_q, base_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   // remaining cells in the current clear; one wider so ROWS*COLS == 2^ADDR_W fits
   logic [ADDR_W:0]     clr_left_q, clr_left_d;
   logic                pend_q, pend_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;

   logic [5:0]          phys_sum;
   logic [4:0]          phys_row;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   base_row_addr;
   logic                newline;

   // sum is at most 2*ROWS-2, so a single conditional subtract gives mod ROWS
   always_comb begin
      phys_sum      = {1'b0, base_q} + {1'b0, row_q};
      phys_row      = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : 5'(phys_sum);
      cur_addr      = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col_q);
      base_row_addr = ADDR_W'(base_q) * ADDR_W'(COLS);
   end

   // a latched or fresh clear always wins over a byte in the same cycle
   assign char_ready = ready_q & ~clear_req;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      base_d     = base_q;
      clr_addr_d = clr_addr_q;
      clr_left_d = clr_left_q;
      pend_d     = pend_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      newline    = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear_req || pend_q) begin
               state_d    = CLR_ALL;
               col_d      = 7'd0;
               row_d      = 5'd0;
               base_d     = 5'd0;
               clr_addr_d = '0;
               clr_left_d = CELLS_CNT;
               pend_d     = 1'b0;
            end else if (char_valid && ready_q) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cur_addr;
                  wr_data_d = char_data;
                  if (col_q == COL_LAST) begin
                     col_d   = 7'd0;
                     newline = 1'b1;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else begin
                  case (char_data)
                     8'h0D: col_d = 7'd0;
                     8'h0A: begin
                        col_d   = 7'd0;
                        newline = 1'b1;
                     end
                     8'h08: begin
                        if (col_q != 7'd0) begin
                           col_d     = col_q - 7'd1;
                           wr_en_d   = 1'b1;
                           wr_addr_d = cur_addr - ADDR_W'(1);
                           wr_data_d = BLANK;
                        end
                     end
                     default: ;
                  endcase
               end

               if (newline) begin
                  if (row_q != ROW_LAST) begin
                     row_d = row_q + 5'd1;
                  end else begin
                     // old top row becomes the new bottom line and must be blanked
                     base_d     = (base_q == ROW_LAST) ? 5'd0 : base_q + 5'd1;
                     state_d    = CLR_LINE;
                     clr_addr_d = base_row_addr;
                     clr_left_d = COLS_CNT;
                  end
               end
            end
         end

         CLR_LINE, CLR_ALL: begin
            wr_en_d    = 1'b1;
            wr_addr_d  = clr_addr_q;
            wr_data_d  = BLANK;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            clr_left_d = clr_left_q - (ADDR_W + 1)'(1);
            if (clear_req) pend_d = 1'b1;
            if (clr_left_q == (ADDR_W + 1)'(1)) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE) && !pend_d;
      // stays high through the cycle that shows the final clear write
      busy_d  = (state_d != IDLE) || (state_q != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         col_q      <= 7'd0;
         row_q      <= 5'd0;
         base_q     <= 5'd0;
         clr_addr_q <= '0;
         clr_left_q <= '0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         base_q     <= base_d;
         clr_addr_q <= clr_addr_d;
         clr_left_q <= clr_left_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign cursor_col  = col_q;
   assign cursor_row  = row_q;
   assign scroll_base = base_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer. Expected RAM writes are queued as
// stimulus is driven and popped by a monitor as the DUT emits them.
module tb_text_console_writer;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              char_valid = 1'b0;
   logic [7:0]        char_data = 8'h00;
   logic              clear_req = 1'b0;
   logic              char_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [6:0]        cursor_col;
   logic [4:0]        cursor_row;
   logic [4:0]        scroll_base;
   logic              busy;

   int errors   = 0;
   int checks   = 0;
   int wr_count = 0;
   logic [19:0] exp_q[$];

   text_console_writer #(.COLS(80), .ROWS(30), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
      .clk(clk), .rst(rst),
      .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
      .clear_req(clear_req),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cursor_col(cursor_col), .cursor_row(cursor_row),
      .scroll_base(scroll_base), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input int addr, input logic [7:0] data);
      exp_q.push_back({12'(addr), data});
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (wr_en) begin
         logic [19:0] e;
         wr_count++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed addr=%0d data=0x%0h expected=none", wr_addr, wr_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[19:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [7:0] b);
      int n;
      char_data  = b;
      char_valid = 1'b1;
      n = 0;
      while (!char_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("send_timeout", 32'(n), 0);
      else begin
         @(posedge clk); #1;
      end
      char_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      check("drained", 32'(exp_q.size()), 0);
   endtask

   task automatic check_cursor(input string tag, input int row, input int col);
      check({tag, "_row"}, 32'(cursor_row), 32'(row));
      check({tag, "_col"}, 32'(cursor_col), 32'(col));
   endtask

   initial begin
      int wc, n, wc0;

      // reset
      #2 rst = 1'b1;
      #1;
      check("rst_ready", 32'(char_ready), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_busy", 32'(busy), 0);
      check_cursor("rst", 0, 0);
      check("rst_base", 32'(scroll_base), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("ready_before_edge", 32'(char_ready), 0);
      @(posedge clk); #1;
      check("ready_after_reset", 32'(char_ready), 1);

      // back-to-back printables
      expect_wr(0, 8'h48);
      expect_wr(1, 8'h69);
      send(8'h48);
      check("ready_held", 32'(char_ready), 1);
      send(8'h69);
      check_cursor("hi", 0, 2);
      drain(20);
      expect_wr(2, 8'h61); expect_wr(3, 8'h62); expect_wr(4, 8'h63);
      send(8'h61); send(8'h62); send(8'h63);
      drain(20);
      check_cursor("abc", 0, 5);

      // CR, LF and discarded control code make no writes
      wc = wr_count;
      send(8'h0D);
      check_cursor("cr", 0, 0);
      send(8'h0A);
      check_cursor("lf", 1, 0);
      check("lf_base", 32'(scroll_base), 0);
      send(8'h01);
      check_cursor("other", 1, 0);
      repeat (3) @(posedge clk); #1;
      check("ctrl_no_write", 32'(wr_count), 32'(wc));

      // backspace at col 0 and col 4
      send(8'h0A);
      wc = wr_count;
      send(8'h08);
      repeat (3) @(posedge clk); #1;
      check("bs_col0_no_write", 32'(wr_count), 32'(wc));
      check_cursor("bs_col0", 2, 0);
      for (int i = 0; i < 4; i++) expect_wr(160 + i, 8'(8'h77 + i));
      for (int i = 0; i < 4; i++) send(8'(8'h77 + i));
      check_cursor("wxyz", 2, 4);
      expect_wr(163, 8'h20);
      send(8'h08);
      drain(20);
      check_cursor("bs", 2, 3);

      // wrap at end of line
      send(8'h0A);
      for (int i = 0; i < 79; i++) expect_wr(240 + i, 8'(8'h61 + i % 26));
      for (int i = 0; i < 79; i++) send(8'(8'h61 + i % 26));
      expect_wr(319, 8'h41);
      send(8'h41);
      check_cursor("wrap", 4, 0);
      check("wrap_busy", 32'(busy), 0);
      drain(20);

      // scroll on LF at the bottom row
      repeat (25) send(8'h0A);
      check_cursor("bottom", 29, 0);
      for (int i = 0; i < 80; i++) expect_wr(i, 8'h20);
      send(8'h0A);
      check("scroll_busy", 32'(busy), 1);
      check("scroll_base", 32'(scroll_base), 1);
      check_cursor("scroll", 29, 0);
      n = 0;
      while (!char_ready && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      check("ready_low_cycles", 32'(n), 80);
      drain(20);
      check("scroll_busy_done", 32'(busy), 0);

      // physical row wraps back to 0 at logical row 29 with base 1
      expect_wr(0, 8'h5A);
      send(8'h5A);
      check_cursor("after_scroll", 29, 1);
      drain(20);

      // clear_req beats a simultaneous byte; second request latched while busy
      for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
      char_data  = 8'h51;
      char_valid = 1'b1;
      clear_req  = 1'b1;
      #1 check("ready_blocked", 32'(char_ready), 0);
      @(posedge clk); #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      check("clr_busy", 32'(busy), 1);
      check_cursor("clr_home", 0, 0);
      check("clr_base", 32'(scroll_base), 0);
      wc0 = wr_count;
      n = 0;
      while (wr_count < wc0 + 500 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("clr_progress", 32'(wr_count >= wc0 + 500), 1);
      for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      drain(6000);
      check("clr_done_busy", 32'(busy), 0);
      check("clr_done_ready", 32'(char_ready), 1);
      check_cursor("clr_done", 0, 0);
      check("clr_done_base", 32'(scroll_base), 0);
      expect_wr(0, 8'h61); expect_wr(1, 8'h62);
      send(8'h61); send(8'h62);
      drain(20);

      // reset aborts a clear in progress
      for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      wc0 = wr_count;
      n = 0;
      while (wr_count < wc0 + 1000 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_progress", 32'(wr_count >= wc0 + 1000), 1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      check("abort_wr_en", 32'(wr_en), 0);
      check("abort_wr_addr", 32'(wr_addr), 0);
      check("abort_wr_data", 32'(wr_data), 0);
      check("abort_ready", 32'(char_ready), 0);
      check("abort_busy", 32'(busy), 0);
      check_cursor("abort", 0, 0);
      check("abort_base", 32'(scroll_base), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_ready_back", 32'(char_ready), 1);
      wc = wr_count;
      repeat (5) @(posedge clk); #1;
      check("abort_no_write", 32'(wr_count), 32'(wc));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
